// File: rtl/axil_lite_master.sv
// axil_lite_master
// Single-outstanding AXI4-Lite initiator. A simple request/response stream
// is converted into one AXI-Lite write (AW + W + B) or read (AR + R)
// transaction at a time. It is intended to program the AXI_LITE_UART
// register map (data 0x0000, rx 0x0004, baud 0x0008, parity 0x000C,
// status 0x0010) from on-chip logic.
//
// Optional build macro: AXIL_LITE_MASTER_TIMEOUT_EN
//   When defined, a per-transaction watchdog aborts any transaction that
//   stays outside IDLE/RSP for TIMEOUT_CYCLES cycles. The abort drops all
//   AXI valids/readies and returns rsp_resp = 2'b11 with rsp_rdata = 0.
//   When undefined, the block waits for the slave indefinitely, and
//   TIMEOUT_CYCLES is present only for a parameter-compatible interface.
//
// Every output is a flop. a_reset is synchronous and active-high.

module axil_lite_master #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              a_reset,

  // request stream
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,

  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,

  // write-address channel
  output logic [ADDR_W-1:0] M_AXI_LITE_awaddr,
  output logic              M_AXI_LITE_awvalid,
  input  logic              M_AXI_LITE_awready,

  // write-data channel
  output logic [31:0]       M_AXI_LITE_wdata,
  output logic [3:0]        M_AXI_LITE_wstrb,
  output logic              M_AXI_LITE_wvalid,
  input  logic              M_AXI_LITE_wready,

  // write-response channel
  input  logic [1:0]        M_AXI_LITE_bresp,
  input  logic              M_AXI_LITE_bvalid,
  output logic              M_AXI_LITE_bready,

  // read-address channel
  output logic [ADDR_W-1:0] M_AXI_LITE_araddr,
  output logic              M_AXI_LITE_arvalid,
  input  logic              M_AXI_LITE_arready,

  // read-data channel
  input  logic [31:0]       M_AXI_LITE_rdata,
  input  logic [1:0]        M_AXI_LITE_rresp,
  input  logic              M_AXI_LITE_rvalid,
  output logic              M_AXI_LITE_rready
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_AW_W = 3'd1;
  localparam logic [2:0] ST_WR_B    = 3'd2;
  localparam logic [2:0] ST_RD_AR   = 3'd3;
  localparam logic [2:0] ST_RD_R    = 3'd4;
  localparam logic [2:0] ST_RSP     = 3'd5;

  // Response code reported when the watchdog aborts a transaction
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  logic [2:0]        state_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic              rsp_write_r;
  logic [31:0]       rsp_rdata_r;
  logic [1:0]        rsp_resp_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic              awvalid_r;
  logic              wvalid_r;
  logic              bready_r;
  logic              arvalid_r;
  logic              rready_r;

  // Next-state values
  logic [2:0]        state_nxt_s;
  logic              req_ready_nxt_s;
  logic              rsp_valid_nxt_s;
  logic              rsp_write_nxt_s;
  logic [31:0]       rsp_rdata_nxt_s;
  logic [1:0]        rsp_resp_nxt_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic [31:0]       wdata_nxt_s;
  logic [3:0]        wstrb_nxt_s;
  logic              awvalid_nxt_s;
  logic              wvalid_nxt_s;
  logic              bready_nxt_s;
  logic              arvalid_nxt_s;
  logic              rready_nxt_s;

  // Helper decodes
  logic              req_accept_s;   // request handshake this cycle
  logic              busy_s;         // waiting on the slave
  logic              complete_s;     // B or R handshake this cycle
  logic              aw_pending_s;   // AW still outstanding after this cycle
  logic              w_pending_s;    // W still outstanding after this cycle
  logic              tmo_abort_s;    // watchdog fires this cycle

  assign req_accept_s = (state_r == ST_IDLE) && req_ready_r && req_valid;
  assign busy_s       = (state_r == ST_WR_AW_W) || (state_r == ST_WR_B) ||
                        (state_r == ST_RD_AR)   || (state_r == ST_RD_R);
  assign complete_s   = ((state_r == ST_WR_B) && bready_r && M_AXI_LITE_bvalid) ||
                        ((state_r == ST_RD_R) && rready_r && M_AXI_LITE_rvalid);
  assign aw_pending_s = awvalid_r && !M_AXI_LITE_awready;
  assign w_pending_s  = wvalid_r  && !M_AXI_LITE_wready;

`ifdef AXIL_LITE_MASTER_TIMEOUT_EN
  // ---------------------------------------------------------------------
  // Watchdog: cleared on request accept, counts every busy cycle
  // ---------------------------------------------------------------------
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_nxt_s;

  // A completing B/R handshake wins over a same-cycle expiry
  assign tmo_abort_s = busy_s && (tmo_cnt_r == TMO_LAST) && !complete_s;

  // Watchdog counter next value
  always_comb begin
    tmo_cnt_nxt_s = tmo_cnt_r;
    if (req_accept_s) begin
      tmo_cnt_nxt_s = {TMO_W{1'b0}};
    end else if (busy_s && (tmo_cnt_r != TMO_LAST)) begin
      tmo_cnt_nxt_s = tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_nxt_s = tmo_cnt_r;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (a_reset) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_nxt_s;
    end
  end
`else
  assign tmo_abort_s = 1'b0;
`endif

  // Transaction FSM and next-value computation for every output register
  always_comb begin
    state_nxt_s     = state_r;
    req_ready_nxt_s = req_ready_r;
    rsp_valid_nxt_s = rsp_valid_r;
    rsp_write_nxt_s = rsp_write_r;
    rsp_rdata_nxt_s = rsp_rdata_r;
    rsp_resp_nxt_s  = rsp_resp_r;
    addr_nxt_s      = addr_r;
    wdata_nxt_s     = wdata_r;
    wstrb_nxt_s     = wstrb_r;
    awvalid_nxt_s   = awvalid_r;
    wvalid_nxt_s    = wvalid_r;
    bready_nxt_s    = bready_r;
    arvalid_nxt_s   = arvalid_r;
    rready_nxt_s    = rready_r;

    if (tmo_abort_s) begin
      // Error recovery: abandon the slave and report a timeout
      awvalid_nxt_s   = 1'b0;
      wvalid_nxt_s    = 1'b0;
      bready_nxt_s    = 1'b0;
      arvalid_nxt_s   = 1'b0;
      rready_nxt_s    = 1'b0;
      rsp_resp_nxt_s  = RESP_TIMEOUT;
      rsp_rdata_nxt_s = 32'h0000_0000;
      rsp_valid_nxt_s = 1'b1;
      state_nxt_s     = ST_RSP;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_accept_s) begin
            // Capture the request; the same address feeds both AW and AR buses
            addr_nxt_s      = req_addr;
            wdata_nxt_s     = req_wdata;
            wstrb_nxt_s     = req_wstrb;
            rsp_write_nxt_s = req_write;
            req_ready_nxt_s = 1'b0;
            if (req_write) begin
              awvalid_nxt_s = 1'b1;
              wvalid_nxt_s  = 1'b1;
              state_nxt_s   = ST_WR_AW_W;
            end else begin
              arvalid_nxt_s = 1'b1;
              state_nxt_s   = ST_RD_AR;
            end
          end else begin
            // Also raises req_ready on the first cycle out of reset
            req_ready_nxt_s = 1'b1;
          end
        end

        ST_WR_AW_W: begin
          // AW and W retire independently, in either order or together
          awvalid_nxt_s = aw_pending_s;
          wvalid_nxt_s  = w_pending_s;
          if (!aw_pending_s && !w_pending_s) begin
            bready_nxt_s = 1'b1;
            state_nxt_s  = ST_WR_B;
          end else begin
            state_nxt_s  = ST_WR_AW_W;
          end
        end

        ST_WR_B: begin
          if (bready_r && M_AXI_LITE_bvalid) begin
            rsp_resp_nxt_s  = M_AXI_LITE_bresp;
            rsp_rdata_nxt_s = 32'h0000_0000;
            bready_nxt_s    = 1'b0;
            rsp_valid_nxt_s = 1'b1;
            state_nxt_s     = ST_RSP;
          end else begin
            state_nxt_s     = ST_WR_B;
          end
        end

        ST_RD_AR: begin
          if (arvalid_r && M_AXI_LITE_arready) begin
            arvalid_nxt_s = 1'b0;
            rready_nxt_s  = 1'b1;
            state_nxt_s   = ST_RD_R;
          end else begin
            state_nxt_s   = ST_RD_AR;
          end
        end

        ST_RD_R: begin
          if (rready_r && M_AXI_LITE_rvalid) begin
            rsp_rdata_nxt_s = M_AXI_LITE_rdata;
            rsp_resp_nxt_s  = M_AXI_LITE_rresp;
            rready_nxt_s    = 1'b0;
            rsp_valid_nxt_s = 1'b1;
            state_nxt_s     = ST_RSP;
          end else begin
            state_nxt_s     = ST_RD_R;
          end
        end

        ST_RSP: begin
          // Response held stable until consumed
          if (rsp_valid_r && rsp_ready) begin
            rsp_valid_nxt_s = 1'b0;
            req_ready_nxt_s = 1'b1;
            state_nxt_s     = ST_IDLE;
          end else begin
            state_nxt_s     = ST_RSP;
          end
        end

        default: begin
          // Unreachable encoding: park safely with the bus quiet
          awvalid_nxt_s   = 1'b0;
          wvalid_nxt_s    = 1'b0;
          bready_nxt_s    = 1'b0;
          arvalid_nxt_s   = 1'b0;
          rready_nxt_s    = 1'b0;
          rsp_valid_nxt_s = 1'b0;
          req_ready_nxt_s = 1'b0;
          state_nxt_s     = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset forces every output low
  always_ff @(posedge clk) begin
    if (a_reset) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_resp_r  <= 2'b00;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= 32'h0000_0000;
      wstrb_r     <= 4'h0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      req_ready_r <= req_ready_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_write_r <= rsp_write_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
      rsp_resp_r  <= rsp_resp_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      wstrb_r     <= wstrb_nxt_s;
      awvalid_r   <= awvalid_nxt_s;
      wvalid_r    <= wvalid_nxt_s;
      bready_r    <= bready_nxt_s;
      arvalid_r   <= arvalid_nxt_s;
      rready_r    <= rready_nxt_s;
    end
  end

  // Output mapping (all straight from flops)
  assign req_ready          = req_ready_r;
  assign rsp_valid          = rsp_valid_r;
  assign rsp_write          = rsp_write_r;
  assign rsp_rdata          = rsp_rdata_r;
  assign rsp_resp           = rsp_resp_r;
  assign M_AXI_LITE_awaddr  = addr_r;
  assign M_AXI_LITE_awvalid = awvalid_r;
  assign M_AXI_LITE_wdata   = wdata_r;
  assign M_AXI_LITE_wstrb   = wstrb_r;
  assign M_AXI_LITE_wvalid  = wvalid_r;
  assign M_AXI_LITE_bready  = bready_r;
  assign M_AXI_LITE_araddr  = addr_r;
  assign M_AXI_LITE_arvalid = arvalid_r;
  assign M_AXI_LITE_rready  = rready_r;

endmodule

// File: tb/tb_axil_lite_master.sv
// tb_axil_lite_master
// Directed bench for axil_lite_master with a behavioural AXI-Lite UART-like
// slave (baud/parity registers, 32-deep loopback FIFO from data to rx,
// status = FIFO count). Slave handshake delays and error injection are
// controlled from the main sequence.

`timescale 1ns/1ps

module tb_axil_lite_master;

  localparam int ADDR_W = 16;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              a_reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  always #5 clk = ~clk;

  axil_lite_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .a_reset(a_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_LITE_awaddr(awaddr), .M_AXI_LITE_awvalid(awvalid), .M_AXI_LITE_awready(awready),
    .M_AXI_LITE_wdata(wdata), .M_AXI_LITE_wstrb(wstrb), .M_AXI_LITE_wvalid(wvalid),
    .M_AXI_LITE_wready(wready),
    .M_AXI_LITE_bresp(bresp), .M_AXI_LITE_bvalid(bvalid), .M_AXI_LITE_bready(bready),
    .M_AXI_LITE_araddr(araddr), .M_AXI_LITE_arvalid(arvalid), .M_AXI_LITE_arready(arready),
    .M_AXI_LITE_rdata(rdata), .M_AXI_LITE_rresp(rresp), .M_AXI_LITE_rvalid(rvalid),
    .M_AXI_LITE_rready(rready)
  );

  // Every DUT output concatenated, for the "all outputs zero" checks
  logic [109:0] out_bus;
  assign out_bus = {req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
                    awaddr, awvalid, wdata, wstrb, wvalid, bready,
                    araddr, arvalid, rready};

  // ---------------- slave model ----------------
  int          aw_delay = 0;
  int          w_delay  = 0;
  logic        ar_en    = 1'b1;
  logic        b_block  = 1'b0;
  logic        err_mode = 1'b0;
  int          aw_wait;
  int          w_wait;
  logic        aw_got;
  logic        w_got;
  logic [15:0] s_awaddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] baud_q = 32'h0;
  logic [31:0] par_q  = 32'h0;
  logic [31:0] fifo [0:31];
  int          fifo_wp  = 0;
  int          fifo_rp  = 0;
  int          fifo_cnt = 0;

  logic        aw_hs, w_hs, aw_ok, w_ok;
  logic [15:0] wa;
  logic [31:0] wd;
  logic [3:0]  ws;

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid  && (w_wait  >= w_delay);
  assign arready = arvalid && ar_en;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign aw_ok   = aw_got || aw_hs;
  assign w_ok    = w_got || w_hs;
  assign wa      = aw_hs ? awaddr : s_awaddr;
  assign wd      = w_hs ? wdata : s_wdata;
  assign ws      = w_hs ? wstrb : s_wstrb;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (a_reset) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1; else aw_wait <= 0;
      if (wvalid && !wready) w_wait <= w_wait + 1; else w_wait <= 0;
      if (bvalid && bready) begin
        bvalid <= 1'b0;
      end else if (aw_ok && w_ok && !bvalid && !b_block) begin
        bvalid <= 1'b1; bresp <= 2'b00; aw_got <= 1'b0; w_got <= 1'b0;
        if (wa == 16'h0000) begin
          if (fifo_cnt < 32) begin
            fifo[fifo_wp] <= wd; fifo_wp <= (fifo_wp + 1) % 32; fifo_cnt <= fifo_cnt + 1;
          end
        end else if (wa == 16'h0008) baud_q <= merge(baud_q, wd, ws);
        else if (wa == 16'h000C) par_q <= merge(par_q, wd, ws);
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; s_awaddr <= awaddr; end
        if (w_hs) begin w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
      end else if (arvalid && arready) begin
        rvalid <= 1'b1; rresp <= 2'b00;
        case (araddr)
          16'h0004: begin
            if (fifo_cnt > 0) begin
              rdata <= fifo[fifo_rp]; fifo_rp <= (fifo_rp + 1) % 32; fifo_cnt <= fifo_cnt - 1;
            end else rdata <= 32'h0;
          end
          16'h0008: rdata <= baud_q;
          16'h000C: rdata <= par_q;
          16'h0010: begin
            if (err_mode) begin rdata <= 32'hBAD0_0010; rresp <= 2'b10; end
            else rdata <= 32'(fifo_cnt);
          end
          default: rdata <= 32'h0;
        endcase
      end
    end
  end

  // ---------------- handshake monitor ----------------
  logic mon_clr = 1'b0;
  int   aw_hi, w_hi, ar_hi, b_cnt, rsp_cnt;

  always @(posedge clk) begin
    if (mon_clr) begin
      aw_hi <= 0; w_hi <= 0; ar_hi <= 0; b_cnt <= 0; rsp_cnt <= 0;
    end else begin
      if (awvalid) aw_hi <= aw_hi + 1;
      if (wvalid) w_hi <= w_hi + 1;
      if (arvalid) ar_hi <= ar_hi + 1;
      if (bvalid && bready) b_cnt <= b_cnt + 1;
      if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_reset();
    @(negedge clk); mon_clr = 1'b1;
    @(negedge clk); mon_clr = 1'b0;
  endtask

  // Presents a request and returns at the negedge of the cycle after accept
  task automatic issue_req(input logic wr, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("req_accept", 128'(req_ready), 128'(1'b1));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits for rsp_valid; lat counts cycles from the accepting cycle
  task automatic wait_rsp(output int lat);
    int n;
    n = 1;
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    chk("rsp_seen", 128'(rsp_valid), 128'(1'b1));
    lat = n;
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run_txn(input logic wr, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [1:0] resp, output logic [31:0] rd,
                         output logic wecho, output int lat);
    issue_req(wr, a, d, s);
    wait_rsp(lat);
    resp = rsp_resp; rd = rsp_rdata; wecho = rsp_write;
    consume_rsp();
  endtask

  // Write with delayed AW/W acceptance; checks valid durations and single response
  task automatic order_test(input int awd, input int wd_, input int exp_aw, input int exp_w);
    logic [1:0] r; logic [31:0] d; logic we; int lat;
    aw_delay = awd; w_delay = wd_;
    mon_reset();
    run_txn(1'b1, 16'h000C, 32'h0000_0002, 4'hF, r, d, we, lat);
    chk("order_aw_cycles", 128'(aw_hi), 128'(exp_aw));
    chk("order_w_cycles", 128'(w_hi), 128'(exp_w));
    chk("order_resp", 128'(r), 128'(2'b00));
    repeat (5) @(negedge clk);
    chk("order_b_count", 128'(b_cnt), 128'(1));
    chk("order_rsp_count", 128'(rsp_cnt), 128'(1));
    aw_delay = 0; w_delay = 0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [1:0] r; logic [31:0] d; logic we; int lat; int bad; logic [31:0] hold_d;

    vecs[0] = '{1'b1, 16'h0008, 32'h0000_0008, 4'hF, 2'b00, 32'h0000_0000};
    vecs[1] = '{1'b0, 16'h0008, 32'h0000_0000, 4'h0, 2'b00, 32'h0000_0008};
    vecs[2] = '{1'b1, 16'h000C, 32'h0000_0002, 4'hF, 2'b00, 32'h0000_0000};
    vecs[3] = '{1'b1, 16'h000C, 32'hFFFF_FF05, 4'h1, 2'b00, 32'h0000_0000};
    vecs[4] = '{1'b0, 16'h000C, 32'h0000_0000, 4'h0, 2'b00, 32'h0000_0005};
    vecs[5] = '{1'b1, 16'h0008, 32'hAABB_CCDD, 4'hA, 2'b00, 32'h0000_0000};
    vecs[6] = '{1'b0, 16'h0008, 32'h0000_0000, 4'h0, 2'b00, 32'hAA00_CC08};
    vecs[7] = '{1'b1, 16'h0008, 32'h0000_0008, 4'hF, 2'b00, 32'h0000_0000};
    vecs[8] = '{1'b0, 16'h0008, 32'h0000_0000, 4'h0, 2'b00, 32'h0000_0008};

    a_reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0;
    req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'(out_bus), 128'(0));
    a_reset = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", 128'(req_ready), 128'(1'b1));

    // Table: zero-wait slave, minimum latency 3
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r, d, we, lat);
      chk($sformatf("vec%0d_resp", i), 128'(r), 128'(vecs[i].exp_resp));
      chk($sformatf("vec%0d_rdata", i), 128'(d), 128'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_write_echo", i), 128'(we), 128'(vecs[i].wr));
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(3));
    end

    // AW late / W late / both late
    order_test(3, 0, 4, 1);
    order_test(0, 2, 1, 3);
    order_test(2, 2, 3, 3);

    // Loopback: 35 writes, FIFO keeps the first 32
    bad = 0;
    for (int i = 1; i <= 35; i++) begin
      run_txn(1'b1, 16'h0000, 32'(i), 4'hF, r, d, we, lat);
      if (r != 2'b00) bad++;
    end
    chk("loop_write_errors", 128'(bad), 128'(0));
    run_txn(1'b0, 16'h0010, 32'h0, 4'h0, r, d, we, lat);
    chk("loop_status_full", 128'({r, d}), 128'({2'b00, 32'h0000_0020}));
    for (int i = 0; i < 32; i++) begin
      run_txn(1'b0, 16'h0004, 32'h0, 4'h0, r, d, we, lat);
      chk($sformatf("loop_rx%0d", i), 128'({r, d}), 128'({2'b00, 32'(i + 1)}));
    end

    // SLVERR pass-through and response hold under back-pressure
    err_mode = 1'b1;
    issue_req(1'b0, 16'h0010, 32'h0, 4'h0);
    wait_rsp(lat);
    chk("err_resp", 128'(rsp_resp), 128'(2'b10));
    chk("err_rdata", 128'(rsp_rdata), 128'(32'hBAD0_0010));
    hold_d = 32'hBAD0_0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_stable", 128'({rsp_valid, req_ready, rsp_resp, rsp_rdata}),
          128'({1'b1, 1'b0, 2'b10, hold_d}));
    end
    consume_rsp();
    chk("rsp_valid_drop", 128'(rsp_valid), 128'(1'b0));
    chk("req_ready_back", 128'(req_ready), 128'(1'b1));
    err_mode = 1'b0;

    // Reset while waiting in WR_B
    b_block = 1'b1;
    issue_req(1'b1, 16'h000C, 32'h0000_0007, 4'hF);
    lat = 0;
    while (!bready && lat < 20) begin @(negedge clk); lat++; end
    chk("reached_wr_b", 128'(bready), 128'(1'b1));
    a_reset = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", 128'(out_bus), 128'(0));
    a_reset = 1'b0; b_block = 1'b0;
    @(negedge clk);
    chk("req_ready_post_reset", 128'(req_ready), 128'(1'b1));
    run_txn(1'b0, 16'h0008, 32'h0, 4'h0, r, d, we, lat);
    chk("post_reset_read", 128'({r, d, lat[3:0]}), 128'({2'b00, 32'h0000_0008, 4'd3}));

    // Slave that never raises arready
    ar_en = 1'b0;
    mon_reset();
    issue_req(1'b0, 16'h0004, 32'h0, 4'h0);
`ifdef AXIL_LITE_MASTER_TIMEOUT_EN
    wait_rsp(lat);
    chk("tmo_arvalid_cycles", 128'(ar_hi), 128'(TMO));
    chk("tmo_resp", 128'({rsp_resp, rsp_rdata, arvalid}), 128'({2'b11, 32'h0, 1'b0}));
    consume_rsp();
    ar_en = 1'b1;
`else
    repeat (40) @(negedge clk);
    chk("no_tmo_arvalid_held", 128'({arvalid, rsp_valid}), 128'(2'b10));
    chk("no_tmo_arvalid_cycles", 128'(ar_hi), 128'(40));
    a_reset = 1'b1;
    @(negedge clk);
    a_reset = 1'b0; ar_en = 1'b1;
    @(negedge clk);
`endif
    run_txn(1'b0, 16'h000C, 32'h0, 4'h0, r, d, we, lat);
    chk("final_read", 128'({r, d}), 128'({2'b00, 32'h0000_0002}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
